// File: rtl/draw_ship_pkg.sv
`default_nettype none
// ============================================================================
// Module   : draw_ship_pkg
// Brief    : Shared widths, ship defaults and blink-state encoding.
// Revision : 1.0
// ============================================================================
package draw_ship_pkg;

    localparam int unsigned c_timing_w    = 11;
    localparam int unsigned c_rgb_w       = 12;
    localparam int unsigned c_addr_w      = 14;
    localparam int unsigned c_ship_width  = 48;
    localparam int unsigned c_ship_height = 64;
    localparam logic [11:0] c_key_color   = 12'h0F0;
    localparam logic [5:0]  c_blink_last  = 6'd47;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BLINK = 1'b1
    } blink_state_e;

endpackage
`default_nettype wire

// File: rtl/vga_delay.sv
`default_nettype none
// ============================================================================
// Module   : vga_delay
// Brief    : Two-stage delay of the VGA timing bundle; the second stage
//            blanks the colour or replaces it with an overlay colour.
// Revision : 1.0
// ============================================================================
module vga_delay
    import draw_ship_pkg::*;
#(
    parameter int unsigned TW    = c_timing_w,
    parameter int unsigned RGB_W = c_rgb_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TW-1:0]    hcount_in,
    input  logic [TW-1:0]    vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic             ovr_en,
    input  logic [RGB_W-1:0] ovr_rgb,
    output logic [TW-1:0]    hcount_out,
    output logic [TW-1:0]    vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [RGB_W-1:0] rgb_out
);

    typedef struct packed {
        logic [TW-1:0]    hcount;
        logic [TW-1:0]    vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
        logic [RGB_W-1:0] rgb;
    } bus_t;

    bus_t s1_d, s1_q, s2_d, s2_q;

    always_comb begin
        s1_d = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                 vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
        s2_d = s1_q;
        // Blanking wins over the overlay so nothing is drawn in the porches.
        if (s1_q.hblnk || s1_q.vblnk) begin
            s2_d.rgb = '0;
        end else if (ovr_en) begin
            s2_d.rgb = ovr_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign hcount_out = s2_q.hcount;
    assign vcount_out = s2_q.vcount;
    assign hsync_out  = s2_q.hsync;
    assign vsync_out  = s2_q.vsync;
    assign hblnk_out  = s2_q.hblnk;
    assign vblnk_out  = s2_q.vblnk;
    assign rgb_out    = s2_q.rgb;

endmodule
`default_nettype wire

// File: rtl/draw_ship.sv
`default_nettype none
// ============================================================================
// Module   : draw_ship
// Brief    : Overlays a keyed sprite ROM onto the VGA stream with a
//            frame-latched position and a hit-triggered blink.
// Revision : 1.0
// ============================================================================
module draw_ship
    import draw_ship_pkg::*;
#(
    parameter int unsigned       WIDTH     = c_ship_width,
    parameter int unsigned       HEIGHT    = c_ship_height,
    parameter logic [c_rgb_w-1:0] KEY_COLOR = c_key_color
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [c_timing_w-1:0] hcount_in,
    input  logic [c_timing_w-1:0] vcount_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  hblnk_in,
    input  logic                  vblnk_in,
    input  logic [c_rgb_w-1:0]    rgb_in,
    input  logic [11:0]           xpos,
    input  logic [11:0]           ypos,
    input  logic                  hit,
    input  logic [c_rgb_w-1:0]    rgb_pixel,
    output logic [c_addr_w-1:0]   pixel_addr,
    output logic [c_timing_w-1:0] hcount_out,
    output logic [c_timing_w-1:0] vcount_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  hblnk_out,
    output logic                  vblnk_out,
    output logic [c_rgb_w-1:0]    rgb_out,
    output logic                  blinking
);

    logic                vblnk_prev_d, vblnk_prev_q;
    logic [11:0]         x_lat_d, x_lat_q, y_lat_d, y_lat_q;
    logic                in_rect_d, in_rect_q;
    logic [c_addr_w-1:0] pixel_addr_d, pixel_addr_q;
    blink_state_e        state_d, state_q;
    logic [5:0]          fcnt_d, fcnt_q;
    logic                blinking_d, blinking_q;

    logic                frame_start;
    logic [12:0]         x_end, y_end;
    logic                visible;
    logic                sprite_en;

    // Stage 1: position latch, hit test and ROM address.
    always_comb begin
        frame_start  = vblnk_in & ~vblnk_prev_q;
        vblnk_prev_d = vblnk_in;
        x_lat_d      = frame_start ? xpos : x_lat_q;
        y_lat_d      = frame_start ? ypos : y_lat_q;
        x_end        = {1'b0, x_lat_q} + 13'(WIDTH);
        y_end        = {1'b0, y_lat_q} + 13'(HEIGHT);
        in_rect_d    = ({1'b0, x_lat_q} <= {2'b0, hcount_in}) && ({2'b0, hcount_in} < x_end) &&
                       ({1'b0, y_lat_q} <= {2'b0, vcount_in}) && ({2'b0, vcount_in} < y_end);
        pixel_addr_d = pixel_addr_q;
        if (in_rect_d) begin
            pixel_addr_d = {vcount_in[6:0] - y_lat_q[6:0], hcount_in[6:0] - x_lat_q[6:0]};
        end
    end

    // Blink FSM: a hit always restarts the 48-frame window, even on a frame start.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (hit) begin
            state_d = ST_BLINK;
            fcnt_d  = 6'd0;
        end else if (state_q == ST_BLINK && frame_start) begin
            if (fcnt_q == c_blink_last) begin
                state_d = ST_IDLE;
                fcnt_d  = 6'd0;
            end else begin
                fcnt_d = fcnt_q + 6'd1;
            end
        end
        blinking_d = (state_d == ST_BLINK);
        visible    = (state_q == ST_IDLE) | ~fcnt_q[3];
        sprite_en  = in_rect_q & visible & (rgb_pixel != KEY_COLOR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vblnk_prev_q <= 1'b0;
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            in_rect_q    <= 1'b0;
            pixel_addr_q <= '0;
            state_q      <= ST_IDLE;
            fcnt_q       <= '0;
            blinking_q   <= 1'b0;
        end else begin
            vblnk_prev_q <= vblnk_prev_d;
            x_lat_q      <= x_lat_d;
            y_lat_q      <= y_lat_d;
            in_rect_q    <= in_rect_d;
            pixel_addr_q <= pixel_addr_d;
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            blinking_q   <= blinking_d;
        end
    end

    assign pixel_addr = pixel_addr_q;
    assign blinking   = blinking_q;

    vga_delay #(
        .TW    (c_timing_w),
        .RGB_W (c_rgb_w)
    ) u_vga_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .ovr_en     (sprite_en),
        .ovr_rgb    (rgb_pixel),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_draw_ship.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_draw_ship
// Brief    : Directed scoreboard bench for draw_ship.
// Revision : 1.0
// ============================================================================
module tb_draw_ship;

    localparam logic [11:0] c_bg = 12'h123;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos;
    logic        hit;
    logic [11:0] rgb_pixel;
    logic [13:0] pixel_addr;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        blinking;

    draw_ship dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .hit        (hit),
        .rgb_pixel  (rgb_pixel),
        .pixel_addr (pixel_addr),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .blinking   (blinking)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic [10:0] hc;
        logic [10:0] vc;
        logic [3:0]  ctl;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;

    logic [11:0] m_x, m_y;
    logic        m_vprev, m_blink;
    logic [5:0]  m_fcnt;
    logic [13:0] m_addr;

    // Sprite ROM: origin is 12'hABC, (x=3,y=2) holds the key colour.
    function automatic logic [11:0] rom(input logic [13:0] a);
        if (a == 14'h0000) return 12'hABC;
        if (a == {7'd2, 7'd3}) return 12'h0F0;
        return a[11:0] ^ {a[13:12], 10'h1A5};
    endfunction

    always_comb rgb_pixel = rom(pixel_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_x = '0; m_y = '0; m_vprev = 1'b0; m_blink = 1'b0; m_fcnt = '0; m_addr = '0;
    endtask

    task automatic cycle(input logic [10:0] hc, input logic [10:0] vc, input logic hb,
                         input logic vb, input logic [11:0] rgb, input logic h);
        exp_t        e;
        int          hx, vy, mx, my;
        bit          inr, fs, vis;
        logic [11:0] pix;
        hcount_in = hc; vcount_in = vc; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb; hit = h;
        hsync_in  = 1'($urandom_range(0, 1));
        vsync_in  = 1'($urandom_range(0, 1));
        if (rst_n) begin
            hx = int'(hc); vy = int'(vc); mx = int'(m_x); my = int'(m_y);
            inr = (hx >= mx) && (hx < mx + 48) && (vy >= my) && (vy < my + 64);
            if (inr) m_addr = 14'((((vy - my) % 128) * 128) + ((hx - mx) % 128));
            fs      = vb && !m_vprev;
            m_vprev = vb;
            if (fs) begin m_x = xpos; m_y = ypos; end
            if (h) begin
                m_blink = 1'b1; m_fcnt = 6'd0;
            end else if (m_blink && fs) begin
                if (m_fcnt == 6'd47) begin m_blink = 1'b0; m_fcnt = 6'd0; end
                else m_fcnt = m_fcnt + 6'd1;
            end
            vis   = !m_blink || !(m_fcnt inside {[6'd8:6'd15], [6'd24:6'd31], [6'd40:6'd47]});
            pix   = rom(m_addr);
            e.rgb = (hb || vb) ? 12'h000 : ((inr && vis && pix != 12'h0F0) ? pix : rgb);
            e.hc  = hc; e.vc = vc; e.ctl = {hsync_in, vsync_in, hb, vb};
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
            sb_q.delete();
            chk("rst_rgb_out", 32'(rgb_out), 32'h0);
            chk("rst_pixel_addr", 32'(pixel_addr), 32'h0);
            chk("rst_counts", {10'd0, hcount_out, vcount_out}, 32'h0);
            chk("rst_ctl", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
            chk("rst_blinking", 32'(blinking), 32'h0);
        end else begin
            chk("pixel_addr", 32'(pixel_addr), 32'(m_addr));
            chk("blinking", 32'(blinking), 32'(m_blink));
            if (sb_q.size() == 2) begin
                e = sb_q.pop_front();
                chk("rgb_out", 32'(rgb_out), 32'(e.rgb));
                chk("hcount_out", 32'(hcount_out), 32'(e.hc));
                chk("vcount_out", 32'(vcount_out), 32'(e.vc));
                chk("ctl_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(e.ctl));
            end
        end
    endtask

    // One short frame: vblank rise, vblank fall, two probes inside the ship.
    task automatic frame(input logic [10:0] px, input logic [10:0] py, input logic h_fs);
        cycle(11'd0, 11'd600, 1'b1, 1'b1, c_bg, h_fs);
        cycle(11'd0, 11'd0, 1'b1, 1'b0, c_bg, 1'b0);
        cycle(px + 11'd5, py + 11'd5, 1'b0, 1'b0, 12'h456, 1'b0);
        cycle(px + 11'd47, py + 11'd63, 1'b0, 1'b0, 12'h789, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
        hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0; xpos = '0; ypos = '0; hit = 1'b0;
        model_reset();

        repeat (3) cycle(11'd9, 11'd9, 1'b0, 1'b0, c_bg, 1'b1);
        rst_n = 1'b1;
        cycle(11'd5, 11'd7, 1'b0, 1'b0, 12'h321, 1'b0);
        chk("latency_hcount", 32'(hcount_out), 32'h0);
        chk("latency_rgb", 32'(rgb_out), 32'h0);

        xpos = 12'd100; ypos = 12'd200;
        cycle(11'd0, 11'd600, 1'b1, 1'b1, c_bg, 1'b0);
        cycle(11'd0, 11'd0, 1'b1, 1'b0, c_bg, 1'b0);
        cycle(11'd100, 11'd200, 1'b0, 1'b0, c_bg, 1'b0);
        chk("addr_origin", 32'(pixel_addr), 32'h0);
        cycle(11'd148, 11'd210, 1'b0, 1'b0, 12'h3C3, 1'b0);
        chk("rgb_origin", 32'(rgb_out), 32'hABC);
        cycle(11'd147, 11'd263, 1'b0, 1'b0, c_bg, 1'b0);
        chk("addr_corner", 32'(pixel_addr), 32'({7'd63, 7'd47}));
        chk("rgb_right_edge", 32'(rgb_out), 32'h3C3);
        cycle(11'd99, 11'd200, 1'b0, 1'b0, 12'hA11, 1'b0);
        cycle(11'd100, 11'd199, 1'b0, 1'b0, 12'hA22, 1'b0);
        cycle(11'd100, 11'd264, 1'b0, 1'b0, 12'hA33, 1'b0);
        cycle(11'd103, 11'd202, 1'b0, 1'b0, c_bg, 1'b0);
        cycle(11'd110, 11'd210, 1'b1, 1'b0, c_bg, 1'b0);
        chk("rgb_key", 32'(rgb_out), 32'(c_bg));
        cycle(11'd111, 11'd211, 1'b0, 1'b0, c_bg, 1'b0);
        chk("rgb_hblnk", 32'(rgb_out), 32'h0);

        xpos = 12'd300;
        cycle(11'd100, 11'd200, 1'b0, 1'b0, c_bg, 1'b0);
        cycle(11'd300, 11'd200, 1'b0, 1'b0, 12'h5E5, 1'b0);
        frame(11'd300, 11'd200, 1'b0);
        cycle(11'd100, 11'd200, 1'b0, 1'b0, 12'h6E6, 1'b0);
        cycle(11'd300, 11'd200, 1'b0, 1'b0, c_bg, 1'b0);

        cycle(11'd305, 11'd205, 1'b0, 1'b0, c_bg, 1'b1);
        chk("blink_start", 32'(blinking), 32'h1);
        for (int f = 1; f < 20; f++) frame(11'd300, 11'd200, 1'b0);
        frame(11'd300, 11'd200, 1'b1);
        for (int f = 1; f < 48; f++) frame(11'd300, 11'd200, 1'b0);
        chk("blink_last_frame", 32'(blinking), 32'h1);
        frame(11'd300, 11'd200, 1'b0);
        chk("blink_done", 32'(blinking), 32'h0);

        cycle(11'd305, 11'd205, 1'b0, 1'b0, c_bg, 1'b1);
        frame(11'd300, 11'd200, 1'b0);
        frame(11'd300, 11'd200, 1'b0);
        cycle(11'd310, 11'd210, 1'b0, 1'b0, c_bg, 1'b0);
        rst_n = 1'b0;
        cycle(11'd311, 11'd211, 1'b0, 1'b0, c_bg, 1'b0);
        rst_n = 1'b1;
        cycle(11'd20, 11'd20, 1'b0, 1'b0, 12'h777, 1'b0);
        chk("latency_after_rst", 32'(hcount_out), 32'h0);
        cycle(11'd21, 11'd70, 1'b0, 1'b0, 12'h778, 1'b0);
        chk("first_valid_after_rst", 32'(hcount_out), 32'd20);
        xpos = 12'd100; ypos = 12'd200;
        frame(11'd100, 11'd200, 1'b0);
        cycle(11'd100, 11'd200, 1'b0, 1'b0, c_bg, 1'b0);
        cycle(11'd0, 11'd0, 1'b1, 1'b0, c_bg, 1'b0);
        chk("rgb_origin_after_rst", 32'(rgb_out), 32'hABC);
        cycle(11'd0, 11'd0, 1'b1, 1'b0, c_bg, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/draw_ship.md
DRAW_SHIP -- requirements
Module: draw_ship

Interface
REQ-001 Parameter WIDTH, default 48, sprite width in pixels (max 128).
REQ-002 Parameter HEIGHT, default 64, sprite height in pixels (max 128).
REQ-003 Parameter KEY_COLOR, default 12'h0F0, transparent colour; pixels of this value show background.
REQ-004 The ports SHALL be as follows:
  clk          in   1   pixel clock; all logic on rising edge.
  rst_n        in   1   synchronous reset, active-low.
  hcount_in    in   11  horizontal pixel count.
  vcount_in    in   11  vertical line count.
  hsync_in     in   1   horizontal sync.
  vsync_in     in   1   vertical sync.
  hblnk_in     in   1   horizontal blanking.
  vblnk_in     in   1   vertical blanking.
  rgb_in       in   12  background colour {r,g,b}.
  xpos         in   12  ship top-left x.
  ypos         in   12  ship top-left y.
  hit          in   1   one-cycle pulse; starts blink.
  rgb_pixel    in   12  sprite ROM data; valid one cycle after pixel_addr.
  pixel_addr   out  14  sprite ROM address {y_rel[6:0], x_rel[6:0]}.
  hcount_out   out  11  hcount_in delayed 2 cycles.
  vcount_out   out  11  vcount_in delayed 2 cycles.
  hsync_out    out  1   delayed 2 cycles.
  vsync_out    out  1   delayed 2 cycles.
  hblnk_out    out  1   delayed 2 cycles.
  vblnk_out    out  1   delayed 2 cycles.
  rgb_out      out  12  composited colour, aligned with delayed timing.
  blinking     out  1   high while blink FSM is in BLINK.

Function
REQ-005 Pipeline latency SHALL be exactly 2 cycles from any input sample to the corresponding outputs.
REQ-006 Stage 1 SHALL register pixel_addr, the in_rect flag and the timing signals; stage 2 SHALL register rgb_out and the timing outputs.
REQ-007 x_lat/y_lat SHALL capture xpos/ypos only on a frame start (vblnk_in=1 while previous vblnk_in=0); mid-frame changes SHALL have no visible effect.
REQ-008 in_rect SHALL be x_lat<=hcount_in<x_lat+WIDTH and y_lat<=vcount_in<y_lat+HEIGHT, using 13-bit sums (no wrap).
REQ-009 When in_rect, pixel_addr SHALL be {vcount_in-y_lat, hcount_in-x_lat}, each truncated to 7 bits; otherwise it holds its last value.
REQ-010 rgb_out SHALL be 12'h000 if delayed hblnk or vblnk is 1.
REQ-011 Otherwise rgb_out SHALL be rgb_pixel if delayed in_rect=1, visible=1 and rgb_pixel!=KEY_COLOR; else delayed rgb_in.
REQ-012 Blink FSM states: IDLE and BLINK; a 6-bit frame counter fcnt.
REQ-013 IDLE->BLINK on hit=1, with fcnt set to 0.
REQ-014 In BLINK, fcnt SHALL increment on each frame start; visible = ~fcnt[3]; in IDLE visible = 1.
REQ-015 BLINK->IDLE on the frame start at which fcnt=47 (48 frames total); fcnt returns to 0.
REQ-016 hit in BLINK SHALL restart fcnt to 0; hit coincident with a frame start SHALL take priority (fcnt=0, no increment).
REQ-017 blinking SHALL equal (state==BLINK), registered.

Reset
REQ-018 While rst_n=0 at a clock edge, all outputs, pipeline registers, x_lat, y_lat and fcnt SHALL be 0 and the state SHALL be IDLE.
REQ-019 Reset asserted mid-frame or mid-blink SHALL abort immediately; the first valid output SHALL appear 2 cycles after release.

Structure
REQ-020 Shared package SHALL hold the timing widths (11), RGB width (12), ROM address width (14), default ship WIDTH/HEIGHT/KEY_COLOR, and the blink state enum.
REQ-021 One sub-module, vga_delay, SHALL implement the parameterised 2-stage delay of the timing bundle (counts, syncs, blanks, rgb_in).

Verification
REQ-022 xpos=100, ypos=200, after a frame start; hcount=100, vcount=200 -> pixel_addr=14'h0000 after 1 cycle; ROM data 12'hABC -> rgb_out=12'hABC after 2 cycles.
REQ-023 hcount=148, vcount=210 (just right of the ship) -> rgb_out=rgb_in delayed; hcount=147, vcount=263 -> pixel_addr={7'd63,7'd47}.
REQ-024 Inside the ship, ROM data=12'h0F0 -> rgb_out=background 12'h123; hblnk_in=1 inside the ship -> rgb_out=12'h000.
REQ-025 xpos changed from 100 to 300 mid-frame -> ship stays at 100 until the next vblnk rise, then renders at 300.
REQ-026 hit pulse -> blinking=1; ship hidden during frames 8-15 and 24-31; blinking=0 after frame 48; second hit at frame 20 -> restart, 48 more frames.
REQ-027 rst_n=0 during BLINK with sprite on screen -> next cycle all outputs 0, blinking=0; after release, latency is again 2 cycles.
